// File: rtl/instr_encoder.sv
// instr_encoder
// Turns structured micro-op requests into 32-bit RV32I instruction words
// tagged with the instruction-memory byte address each word is written to.
// The LI pseudo-op is expanded into LUI+ADDI when the value does not fit
// a single ADDI. Illegal requests are accepted but emit no word. Each one
// raises err_pulse for one cycle and bumps a saturating counter.
//
// Optional feature: define QGATE_ENCODE_EN to encode class 10 (QGATE) as a
// custom-0 R-type word. Without it, class 10 is treated as illegal.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_cls            0=OP 1=OP_IMM 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR
//                      7=LUI 8=AUIPC 9=LI 10=QGATE
//   req_alu_op         ALU op code (OP / OP_IMM)
//   req_funct3         width / branch condition / gate id
//   req_rd/rs1/rs2     register indices
//   req_imm            immediate (bytes for BRANCH/JAL)
//   addr_load/value    reload address counter (only when idle and empty)
//   out_valid/ready    output word handshake
//   out_instr/addr     encoded word and its byte address
//   err_pulse          one-cycle illegal-request flag
//   err_count          saturating illegal-request count
//   state_dbg          FSM state (0=IDLE, 1=LI_LO)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its payload stable while valid && !ready.
//
// ALU op codes: 0=ADD 1=SUB 2=SLL 3=SLT 4=SLTU 5=XOR 6=SRL 7=SRA 8=OR 9=AND.
// Codes 10..15 are illegal.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_cls,
  input  logic [3:0]          req_alu_op,
  input  logic [2:0]          req_funct3,
  input  logic [4:0]          req_rd,
  input  logic [4:0]          req_rs1,
  input  logic [4:0]          req_rs2,
  input  logic [31:0]         req_imm,
  input  logic                addr_load,
  input  logic [ADDR_W-1:0]   addr_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                state_dbg
);

  localparam logic [3:0] CLS_OP     = 4'd0;
  localparam logic [3:0] CLS_OP_IMM = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_LI     = 4'd9;
  localparam logic [3:0] CLS_QGATE  = 4'd10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;

  state_t              state;
  logic [31:0]         pend_instr;   // ADDI half of a two-word LI
  logic [ADDR_W-1:0]   addr_cnt;     // address of the word at the output head

  logic [2:0]  alu_f3;
  logic        alu_known;
  logic        alu_shift;
  logic [6:0]  f7;
  logic        fits12, fits13, fits21;
  logic [19:0] li_hi;
  logic [31:0] word0, word1;
  logic        li_two, illegal;

  logic accept, consume, out_free, load_first, load_second, addr_load_eff;
  logic [ADDR_W-1:0] word_addr;

  // A value fits an N-bit signed field when all bits above N-2 equal the sign.
  assign fits12 = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
  assign fits13 = (req_imm[31:12] == '0) || (req_imm[31:12] == '1);
  assign fits21 = (req_imm[31:20] == '0) || (req_imm[31:20] == '1);

  // Upper part rounded up when the low 12 bits will be sign-extended negative.
  assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};

  always_comb begin
    alu_f3    = 3'b000;
    alu_known = 1'b1;
    alu_shift = 1'b0;
    case (req_alu_op)
      ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
      ALU_SLL: begin alu_f3 = 3'b001; alu_shift = 1'b1; end
      ALU_SLT:  alu_f3 = 3'b010;
      ALU_SLTU: alu_f3 = 3'b011;
      ALU_XOR:  alu_f3 = 3'b100;
      ALU_SRL, ALU_SRA: begin alu_f3 = 3'b101; alu_shift = 1'b1; end
      ALU_OR:   alu_f3 = 3'b110;
      ALU_AND:  alu_f3 = 3'b111;
      default:  alu_known = 1'b0;
    endcase
  end

  always_comb begin
    word0   = '0;
    word1   = '0;
    li_two  = 1'b0;
    illegal = 1'b0;
    f7      = 7'd0;
    case (req_cls)
      CLS_OP: begin
        if (req_alu_op == ALU_SUB || req_alu_op == ALU_SRA) f7 = F7_ALT;
        if (!alu_known) illegal = 1'b1;
        else word0 = {f7, req_rs2, req_rs1, alu_f3, req_rd, OPC_OP};
      end
      CLS_OP_IMM: begin
        if (req_alu_op == ALU_SRA) f7 = F7_ALT;
        if (!alu_known || req_alu_op == ALU_SUB) illegal = 1'b1;
        else if (alu_shift) begin
          if (req_imm[31:5] != '0) illegal = 1'b1;
          else word0 = {f7, req_imm[4:0], req_rs1, alu_f3, req_rd, OPC_OP_IMM};
        end else if (!fits12) illegal = 1'b1;
        else word0 = {req_imm[11:0], req_rs1, alu_f3, req_rd, OPC_OP_IMM};
      end
      CLS_LOAD: begin
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
            req_funct3 == 3'b111 || !fits12) illegal = 1'b1;
        else word0 = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
      end
      CLS_STORE: begin
        if (req_funct3 > 3'b010 || !fits12) illegal = 1'b1;
        else word0 = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                      req_imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        if (req_funct3 == 3'b010 || req_funct3 == 3'b011 ||
            req_imm[0] || !fits13) illegal = 1'b1;
        else word0 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                      req_imm[4:1], req_imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        if (req_imm[0] || !fits21) illegal = 1'b1;
        else word0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                      req_rd, OPC_JAL};
      end
      CLS_JALR: begin
        if (!fits12) illegal = 1'b1;
        else word0 = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
      end
      CLS_LUI:   word0 = {req_imm[31:12], req_rd, OPC_LUI};
      CLS_AUIPC: word0 = {req_imm[31:12], req_rd, OPC_AUIPC};
      CLS_LI: begin
        if (fits12) word0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OP_IMM};
        else begin
          word0  = {li_hi, req_rd, OPC_LUI};
          word1  = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_OP_IMM};
          li_two = (req_imm[11:0] != 12'd0);
        end
      end
`ifdef QGATE_ENCODE_EN
      CLS_QGATE: word0 = {7'd0, req_rs2, req_rs1, req_funct3, req_rd, OPC_CUST0};
`else
      CLS_QGATE: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign out_free      = !out_valid || out_ready;
  assign req_ready     = (state == IDLE) && out_free;
  assign accept        = req_valid && req_ready;
  assign consume       = out_valid && out_ready;
  assign load_first    = accept && !illegal;
  assign load_second   = (state == LI_LO) && out_free;
  assign addr_load_eff = addr_load && !out_valid && (state == IDLE);
  assign state_dbg     = (state == LI_LO);

  // A word loaded while the head word leaves goes to the following address.
  always_comb begin
    if (addr_load_eff)  word_addr = addr_value;
    else if (consume)   word_addr = addr_cnt + ADDR_W'(4);
    else                word_addr = addr_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_instr <= '0;
      addr_cnt   <= ADDR_W'(BASE_ADDR);
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= ADDR_W'(BASE_ADDR);
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      err_pulse <= accept && illegal;
      if (accept && illegal && (err_count != {ERRCNT_W{1'b1}}))
        err_count <= err_count + ERRCNT_W'(1);

      if (addr_load_eff)  addr_cnt <= addr_value;
      else if (consume)   addr_cnt <= addr_cnt + ADDR_W'(4);

      if (load_first || load_second) begin
        out_valid <= 1'b1;
        out_instr <= load_second ? pend_instr : word0;
        out_addr  <= word_addr;
      end else if (consume) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load_first && li_two) begin
            pend_instr <= word1;
            state      <= LI_LO;
          end
        end
        LI_LO: begin
          if (out_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cls;
  logic [3:0]  req_alu_op;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        addr_load;
  logic [15:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        state_dbg;

  instr_encoder #(.ADDR_W(16), .BASE_ADDR(0), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cls(req_cls), .req_alu_op(req_alu_op), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .addr_load(addr_load), .addr_value(addr_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_addr;
  bit          exp_err_next;
  int          exp_err_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] enc_r(longint unsigned f7, longint unsigned rs2,
      longint unsigned rs1, longint unsigned f3, longint unsigned rd, longint unsigned opc);
    return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc);
  endfunction

  function automatic logic [31:0] enc_i(longint unsigned imm12, longint unsigned rs1,
      longint unsigned f3, longint unsigned rd, longint unsigned opc);
    return 32'(imm12 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc);
  endfunction

  // n = number of words emitted (0 means illegal request)
  function automatic void model(input int cls, input int op, input int f3, input int rd,
      input int rs1, input int rs2, input logic [31:0] immu,
      output int n, output logic [31:0] w0, output logic [31:0] w1);
    int alu_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    longint          s    = longint'($signed(immu));
    longint unsigned u    = {32'd0, immu};
    longint unsigned lo12 = u % 4096;
    longint unsigned ub   = u % 8192;
    longint unsigned uj   = u % 2097152;
    longint unsigned hi;
    bit fit12 = (s >= -2048) && (s <= 2047);
    n = 1; w0 = '0; w1 = '0;
    case (cls)
      0: if (op > 9) n = 0;
         else w0 = enc_r((op == 1 || op == 7) ? 32 : 0, rs2, rs1, alu_f3[op], rd, 51);
      1: begin
        if (op > 9 || op == 1) n = 0;
        else if (op == 2 || op == 6 || op == 7) begin
          if (u > 31) n = 0;
          else w0 = enc_r(op == 7 ? 32 : 0, u, rs1, alu_f3[op], rd, 19);
        end else if (!fit12) n = 0;
        else w0 = enc_i(lo12, rs1, alu_f3[op], rd, 19);
      end
      2: if (f3 == 3 || f3 == 6 || f3 == 7 || !fit12) n = 0;
         else w0 = enc_i(lo12, rs1, f3, rd, 3);
      3: if (f3 > 2 || !fit12) n = 0;
         else w0 = enc_r(lo12 / 32, rs2, rs1, f3, lo12 % 32, 35);
      4: if (f3 == 2 || f3 == 3 || (s % 2) != 0 || s < -4096 || s > 4095) n = 0;
         else w0 = enc_r(((ub / 4096) % 2) * 64 + (ub / 32) % 64, rs2, rs1, f3,
                         ((ub / 2) % 16) * 2 + (ub / 2048) % 2, 99);
      5: if ((s % 2) != 0 || s < -1048576 || s > 1048575) n = 0;
         else w0 = 32'((((uj / 1048576) % 2) * 524288 + ((uj / 2) % 1024) * 512 +
                        ((uj / 2048) % 2) * 256 + (uj / 4096) % 256) * 4096 + rd * 128 + 111);
      6: if (!fit12) n = 0;
         else w0 = enc_i(lo12, rs1, 0, rd, 103);
      7: w0 = 32'((u / 4096) * 4096 + rd * 128 + 55);
      8: w0 = 32'((u / 4096) * 4096 + rd * 128 + 23);
      9: begin
        if (fit12) w0 = enc_i(lo12, 0, 0, rd, 19);
        else begin
          hi = ((u + 2048) / 4096) % 1048576;
          w0 = 32'(hi * 4096 + rd * 128 + 55);
          if (lo12 != 0) begin
            n  = 2;
            w1 = enc_i(lo12, rd, 0, rd, 19);
          end
        end
      end
`ifdef QGATE_ENCODE_EN
      10: w0 = enc_r(0, rs2, rs1, f3, rd, 11);
`endif
      default: n = 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] bnd[16] = '{32'hFFFF_F7FF, 32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800,
                             32'h0000_0000, 32'h0000_0FFF, 32'hFFFF_F000, 32'hFFFF_EFFF,
                             32'h0000_1000, 32'h0000_001F, 32'h0000_0020, 32'hFFFF_FFFF,
                             32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000, 32'h0000_0FFE};
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      2: return bnd[$urandom_range(0, 15)];
      3: return 32'($urandom_range(0, 16383)) - 32'd8192;
      4: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int cls, input int op, input int f3, input int rd,
      input int rs1, input int rs2, input logic [31:0] imm);
    req_cls    = 4'(cls);
    req_alu_op = 4'(op);
    req_funct3 = 3'(f3);
    req_rd     = 5'(rd);
    req_rs1    = 5'(rs1);
    req_rs2    = 5'(rs2);
    req_imm    = imm;
    req_valid  = 1'b1;
  endtask

  // One clock: sample just after the falling edge, then wait for the next one.
  task automatic tick(output bit acc);
    int n;
    logic [31:0] w0, w1;
    bit exp_ready;
    #1;
    if (addr_load && exp_q.size() == 0) exp_addr = int'(addr_value);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("req_ready", req_ready, exp_ready);
    chk("err_pulse", err_pulse, exp_err_next);
    chk("err_count", err_count, exp_err_cnt);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      chk("word_instr", out_instr, exp_q.pop_front());
      chk("word_addr", out_addr, exp_addr);
      exp_addr = (exp_addr + 4) % 65536;
    end
    exp_err_next = 1'b0;
    acc = req_valid && req_ready;
    if (acc) begin
      model(int'(req_cls), int'(req_alu_op), int'(req_funct3), int'(req_rd),
            int'(req_rs1), int'(req_rs2), req_imm, n, w0, w1);
      if (n == 0) begin
        exp_err_next = 1'b1;
        if (exp_err_cnt < 255) exp_err_cnt++;
      end else begin
        exp_q.push_back(w0);
        if (n == 2) exp_q.push_back(w1);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int cls, input int op, input int f3, input int rd,
      input int rs1, input int rs2, input logic [31:0] imm, input bit rnd);
    bit acc = 1'b0;
    set_req(cls, op, f3, rd, rs1, rs2, imm);
    for (int k = 0; k < 64 && !acc; k++) begin
      if (rnd) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        addr_load  = ($urandom_range(0, 15) == 0);
        addr_value = 16'($urandom) & 16'hFFFC;
      end
      tick(acc);
    end
    chk("accept_in_time", acc, 1);
    req_valid = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bit acc;
    req_valid = 1'b0;
    for (int k = 0; k < cycles; k++) tick(acc);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit acc;
    checks = 0; failures = 0;
    exp_addr = 0; exp_err_next = 1'b0; exp_err_cnt = 0;
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    addr_load = 1'b0; addr_value = '0;
    set_req(0, 0, 0, 0, 0, 0, 32'd0);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // OP ADD / SUB with one-cycle latency
    send(0, 0, 0, 3, 1, 2, 32'd0, 1'b0);
    chk("add_latency", out_valid, 1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 16'h0000);
    send(0, 1, 0, 5, 6, 7, 32'd0, 1'b0);
    chk("sub_instr", out_instr, 32'h407302B3);
    chk("sub_addr", out_addr, 16'h0004);

    // LI expansion with the consumer stalled during the second word
    send(9, 0, 0, 10, 0, 0, 32'h12345FFF, 1'b0);
    chk("li_lui", out_instr, 32'h12346537);
    chk("li_state", state_dbg, 1);
    out_ready = 1'b0;
    set_req(9, 0, 0, 1, 0, 0, 32'd5);
    tick(acc); tick(acc);
    out_ready = 1'b1;
    send(9, 0, 0, 1, 0, 0, 32'd5, 1'b0);
    chk("li_small", out_instr, 32'h00500093);

    // Out-of-range OP_IMM immediate
    send(1, 0, 0, 1, 1, 0, 32'd2048, 1'b0);
    chk("illegal_pulse", err_pulse, 1);
    chk("illegal_no_word", out_valid, 0);
    idle(2);

    // Backpressure: word held for 3 cycles, next request taken on release
    send(0, 0, 0, 4, 4, 4, 32'd0, 1'b0);
    out_ready = 1'b0;
    set_req(0, 5, 0, 8, 9, 10, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("stall_instr", out_instr, exp_q[0]);
      chk("stall_addr", out_addr, exp_addr);
      chk("stall_no_accept", acc, 0);
    end
    out_ready = 1'b1;
    tick(acc);
    chk("stall_release_accept", acc, 1);
    req_valid = 1'b0;
    drain();

    // Address reload and wrap
    addr_load = 1'b1; addr_value = 16'hFFFC;
    idle(1);
    addr_load = 1'b0;
    send(0, 8, 0, 1, 2, 3, 32'd0, 1'b0);
    send(0, 9, 0, 4, 5, 6, 32'd0, 1'b0);
    drain();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      send($urandom_range(0, 15), $urandom_range(0, 11), $urandom_range(0, 7),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           rand_imm(), 1'b1);
    drain();

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(15, 0, 0, 0, 0, 0, 32'd0, 1'b0);
    idle(1);
    chk("err_saturated", err_count, 8'hFF);

    // Reset during LI_LO drops the pending second word
    send(9, 0, 0, 7, 0, 0, 32'h76543210, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("pre_rst_state", state_dbg, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_out_instr", out_instr, 0);
    exp_q.delete();
    exp_addr = 0; exp_err_next = 1'b0; exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(5);
    send(0, 0, 0, 3, 1, 2, 32'd0, 1'b0);
    chk("post_rst_addr", out_addr, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
